// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment driver with hex decode,
// frame-aligned double buffering, leading-zero suppression and per-digit decimal points.
// Optional build macro SEG7_DIM_EN adds a 4-bit brightness input that PWM-gates the anodes.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_blank,
`ifdef SEG7_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW   = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(DIGITS - 1);

  logic [PW-1:0]         r_presc;
  logic [IDXW-1:0]       r_idx;
  logic                  r_tick;
  logic                  r_adv;       // high the cycle after the index moved (or after reset)
  logic [4*DIGITS-1:0]   r_shadow_val;
  logic [DIGITS-1:0]     r_shadow_dp;
  logic [4*DIGITS-1:0]   r_disp_val;
  logic [DIGITS-1:0]     r_disp_dp;
  logic [DIGITS-1:0]     r_an_act;
  logic [6:0]            r_seg_act;
  logic                  r_dp_act;

  logic                  w_term;
  logic                  w_last;
  logic [3:0]            w_nib [DIGITS];
  logic [DIGITS-1:0]     w_lead;      // digit and everything left of it are zero
  logic [DIGITS-1:0]     w_onehot;
  logic                  w_blank;
  logic                  w_an_gate;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'b0111111;
      4'h1: pat = 7'b0000110;
      4'h2: pat = 7'b1011011;
      4'h3: pat = 7'b1001111;
      4'h4: pat = 7'b1100110;
      4'h5: pat = 7'b1101101;
      4'h6: pat = 7'b1111101;
      4'h7: pat = 7'b0000111;
      4'h8: pat = 7'b1111111;
      4'h9: pat = 7'b1101111;
      4'hA: pat = 7'b1110111;
      4'hB: pat = 7'b1111100;
      4'hC: pat = 7'b0111001;
      4'hD: pat = 7'b1011110;
      4'hE: pat = 7'b1111001;
      default: pat = 7'b1110001;
    endcase
    return pat;
  endfunction

  assign w_term = (r_presc == PRESC_LAST);
  assign w_last = (r_idx == IDX_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_nib[gi]  = r_disp_val[4*gi +: 4];
      assign w_lead[gi] = ~|r_disp_val[4*DIGITS-1 : 4*gi];
    end
  endgenerate

  // One-hot digit select for the current scan index.
  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  // Digit 0 is never blanked so an all-zero value still shows a single "0".
  assign w_blank = lz_blank & w_lead[r_idx] & (r_idx != '0);

`ifdef SEG7_DIM_EN
  logic [3:0] r_pwm;

  // Free-running PWM phase counter for anode dimming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pwm <= 4'd0;
    else       r_pwm <= r_pwm + 4'd1;
  end

  assign w_an_gate = (brightness == 4'hF) || (r_pwm < brightness);
`else
  assign w_an_gate = 1'b1;
`endif

  // Prescaler, scan index, frame pulse and frame-aligned display buffer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_tick     <= 1'b0;
      r_adv      <= 1'b1;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
    end else begin
      r_tick <= 1'b0;
      r_adv  <= 1'b0;
      if (w_term) begin
        r_presc <= '0;
        r_adv   <= 1'b1;
        if (w_last) begin
          r_idx      <= '0;
          r_tick     <= 1'b1;
          r_disp_val <= r_shadow_val;
          r_disp_dp  <= r_shadow_dp;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Shadow buffer captures new data on a load strobe; display copies it at the wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
    end else if (load) begin
      r_shadow_val <= value;
      r_shadow_dp  <= dp_in;
    end
  end

  // Registered pin drivers; segment data (and lz_blank) is latched once per digit slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an_act  <= '0;
      r_seg_act <= '0;
      r_dp_act  <= 1'b0;
    end else begin
      r_an_act <= w_an_gate ? w_onehot : '0;
      if (r_adv) begin
        r_seg_act <= w_blank ? 7'd0 : hex_decode(w_nib[r_idx]);
        r_dp_act  <= r_disp_dp[r_idx];
      end
    end
  end

  assign an         = r_an_act ^ {DIGITS{ACTIVE_LOW}};
  assign seg        = r_seg_act ^ {7{ACTIVE_LOW}};
  assign dp         = r_dp_act ^ ACTIVE_LOW;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1).
// A reference model indexed by the clock-edge count since reset release predicts every
// output each cycle; table vectors and hand sequences add targeted per-digit checks.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
`ifdef SEG7_DIM_EN
  logic [3:0]  brightness = 4'hF;
`endif
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .dp_in(dp_in),
    .load(load),
    .lz_blank(lz_blank),
`ifdef SEG7_DIM_EN
    .brightness(brightness),
`endif
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Active-high hex patterns {g,f,e,d,c,b,a}.
  logic [6:0] dec_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  // Model state (active-high expectations).
  int          n;
  logic [15:0] m_sh_val, m_disp_val;
  logic [3:0]  m_sh_dp, m_disp_dp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_tick;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_sh_val = '0; m_sh_dp = '0; m_disp_val = '0; m_disp_dp = '0;
    e_an = '0; e_seg = '0; e_dp = 1'b0; e_tick = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int d;
    logic [15:0] upper;
    n++;
    d = ((n - 1) / 4) % 4;
    if ((n - 1) % 4 == 0) begin
      upper = m_disp_val >> (4 * d);
      if (lz_blank && d != 0 && upper == 16'h0) e_seg = 7'd0;
      else e_seg = dec_tab[upper[3:0]];
      e_dp = m_disp_dp[d];
    end
    e_an = 4'(1 << d);
`ifdef SEG7_DIM_EN
    if (!(brightness == 4'hF || ((n - 1) % 16) < int'(brightness))) e_an = 4'h0;
`endif
    e_tick = (n % 16 == 0);
    if (n % 16 == 0) begin
      m_disp_val = m_sh_val;
      m_disp_dp  = m_sh_dp;
    end
    if (load) begin
      m_sh_val = value;
      m_sh_dp  = dp_in;
    end
  endtask

  task automatic check_outs();
    logic [3:0] xa;
    logic [6:0] xs;
    logic       xd;
    xa = ~e_an; xs = ~e_seg; xd = ~e_dp;
    chk("an", an, xa);
    chk("seg", seg, xs);
    chk("dp", dp, xd);
    chk("frame_tick", frame_tick, e_tick);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpi;
    logic        lz;
    logic [27:0] s;    // pin-level seg {d3,d2,d1,d0}
    logic [3:0]  dpo;  // pin-level dp  {d3,d2,d1,d0}
  } vec_t;

  vec_t tv [6];
  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];

  task automatic capture_frame();
    for (int k = 0; k < 16; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        if (an[d] == 1'b0) begin
          cap_seg[d] = seg;
          cap_dp[d]  = dp;
        end
      end
    end
  endtask

  task automatic wait_tick(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (frame_tick) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
  endtask

  initial begin
    logic [15:0] mask;
    int on_cnt;

    tv[0] = '{16'h1234, 4'b0100, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011};
    tv[1] = '{16'h0050, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111};
    tv[2] = '{16'h0000, 4'b1000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b0111};
    tv[3] = '{16'hABCD, 4'b0001, 1'b0, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'b1110};
    tv[4] = '{16'hE0F0, 4'b0000, 1'b1, {7'b0000110, 7'b1000000, 7'b0001110, 7'b1000000}, 4'b1111};
    tv[5] = '{16'h0809, 4'b0010, 1'b1, {7'b1111111, 7'b0000000, 7'b1000000, 7'b0010000}, 4'b1101};
    for (int d = 0; d < 4; d++) begin cap_seg[d] = '0; cap_dp[d] = 1'b0; end

    // Power-on reset state.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_tick", frame_tick, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Free run: first digit after one edge, advance after four more.
    step();
    chk("first_an", an, 4'b1110);
    repeat (4) step();
    chk("second_an", an, 4'b1101);
    repeat (40) step();

    // Table-driven per-digit decode, blanking and decimal points.
    for (int v = 0; v < 6; v++) begin
      value = tv[v].val; dp_in = tv[v].dpi; lz_blank = tv[v].lz; load = 1'b1;
      step();
      load = 1'b0;
      wait_tick("vec_tick_wait");
      capture_frame();
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("vec%0d_seg_d%0d", v, d), cap_seg[d], tv[v].s[7*d +: 7]);
        chk($sformatf("vec%0d_dp_d%0d", v, d), cap_dp[d], tv[v].dpo[d]);
      end
      $display("vector %0d: value=%h dp_in=%b lz=%0d checked", v, tv[v].val, tv[v].dpi, tv[v].lz);
    end

    // Load on the wrap edge: old data for one whole frame, new data the frame after.
    lz_blank = 1'b0; value = 16'h1234; dp_in = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    wait_tick("wrap_pre_tick");
    for (int k = 0; k < 20 && ((n + 1) % 16 != 0); k++) step();
    value = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;
    chk("wrap_load_tick", frame_tick, 1'b1);
    capture_frame();
    chk("wrap_old_d0", cap_seg[0], 7'b0011001);
    capture_frame();
    chk("wrap_new_d0", cap_seg[0], 7'b0000000);
    $display("load-at-wrap sequence checked");

    // Asynchronous reset mid-slot, then restart from digit 0.
    repeat (6) step();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_dp", dp, 1'b1);
    chk("async_rst_tick", frame_tick, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_an", an, 4'hF);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step();
    chk("restart_an", an, 4'b1110);
    chk("restart_seg", seg, 7'b1000000);
    repeat (3) step();
    chk("restart_hold_an", an, 4'b1110);
    step();
    chk("restart_adv_an", an, 4'b1101);
    $display("mid-run reset sequence checked");

    // Randomized run against the model, with live lz_blank toggles.
    for (int k = 0; k < 800; k++) begin
      case ($urandom_range(0, 3))
        0: mask = 16'h000F;
        1: mask = 16'h00FF;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      value = 16'($urandom) & mask;
      dp_in = 4'($urandom);
      load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
      step();
    end
    load = 1'b0;
    $display("random run done at edge %0d", n);

`ifdef SEG7_DIM_EN
    brightness = 4'd4;
    repeat (16) step();
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin step(); if (an != 4'hF) on_cnt++; end
    chk("dim4_on_cycles", on_cnt, 4);
    brightness = 4'd0;
    step();
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin step(); if (an != 4'hF) on_cnt++; end
    chk("dim0_on_cycles", on_cnt, 0);
    brightness = 4'hF;
    step();
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin step(); if (an != 4'hF) on_cnt++; end
    chk("dim15_on_cycles", on_cnt, 16);
    $display("brightness sequence checked");
`else
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin step(); if (an != 4'hF) on_cnt++; end
    chk("full_on_cycles", on_cnt, 16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
